// File: rtl/regbus_sequencer_pkg.sv
// regbus_sequencer_pkg: command and sequencer state encodings shared by the register/bus unit and its bench
package regbus_sequencer_pkg;
  typedef enum logic [1:0] {
    OP_MV   = 2'b00,
    OP_MVI  = 2'b01,
    OP_SWAP = 2'b10,
    OP_CLR  = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T1   = 2'b01,
    S_T2   = 2'b10,
    S_T3   = 2'b11
  } state_e;
endpackage

// File: rtl/regbus_sequencer_if.sv
// regbus_sequencer_if: command handshake (run/ready/op/rx/ry/din) plus results (done/bus/regs); master drives commands, slave is the unit
interface regbus_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
);
  logic                   run;
  logic                   ready;
  logic [1:0]             op;
  logic [AW-1:0]          rx;
  logic [AW-1:0]          ry;
  logic [WIDTH-1:0]       din;
  logic                   done;
  logic [WIDTH-1:0]       bus;
  logic [NREGS*WIDTH-1:0] regs;
  modport master (output run, op, rx, ry, din, input ready, done, bus, regs);
  modport slave  (input run, op, rx, ry, din, output ready, done, bus, regs);
endinterface

// File: rtl/regbus_sequencer_reg_en_ar.sv
// reg_en_ar: WIDTH-bit register loading d_i when en_i is high, async active-high clear on rst; ports clk, rst, en_i, d_i -> q_o
module reg_en_ar #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else if (en_i) q_q <= d_i;
  assign q_o = q_q;
endmodule

// File: rtl/regbus_sequencer.sv
// regbus_sequencer: NREGS x WIDTH register file on one shared bus with a MV/MVI/SWAP/CLR sequencer; ports clk, rst, bus_if (slave: run/op/rx/ry/din in, ready/done/bus/regs out)
module regbus_sequencer
  import regbus_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input logic               clk,
  input logic               rst,
  regbus_sequencer_if.slave bus_if
);
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    rx_q, rx_d, ry_q, ry_d;
  logic [WIDTH-1:0] r [NREGS];
  logic [WIDTH-1:0] t_q, bus;
  logic             accept, swap, wr_en, t_en;
  logic [AW-1:0]    wr_idx;
  always_comb begin
    accept  = state_q == S_IDLE && bus_if.run;
    swap    = op_q == OP_SWAP;
    op_d    = accept ? op_e'(bus_if.op) : op_q;
    rx_d    = accept ? bus_if.rx : rx_q;
    ry_d    = accept ? bus_if.ry : ry_q;
    state_d = state_q == S_IDLE ? (bus_if.run ? S_T1 : S_IDLE) :
              state_q == S_T1   ? (swap ? S_T2 : S_IDLE) :
              state_q == S_T2   ? S_T3 : S_IDLE;
    bus     = state_q == S_T1 ? (op_q == OP_MV  ? r[ry_q] :
                                 op_q == OP_MVI ? bus_if.din :
                                 swap           ? r[rx_q] : '0) :
              state_q == S_T2 ? r[ry_q] :
              state_q == S_T3 ? t_q : '0;
    t_en    = state_q == S_T1 && swap;
    wr_en   = (state_q == S_T1 && !swap) || state_q == S_T2 || state_q == S_T3;
    wr_idx  = state_q == S_T3 ? ry_q : rx_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MV;
      rx_q    <= '0;
      ry_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
    end
  reg_en_ar #(.WIDTH(WIDTH)) u_t (
    .clk (clk),
    .rst (rst),
    .en_i(t_en),
    .d_i (bus),
    .q_o (t_q)
  );
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    reg_en_ar #(.WIDTH(WIDTH)) u_r (
      .clk (clk),
      .rst (rst),
      .en_i(wr_en && wr_idx == AW'(i)),
      .d_i (bus),
      .q_o (r[i])
    );
    assign bus_if.regs[i*WIDTH +: WIDTH] = r[i];
  end
  assign bus_if.bus   = bus;
  assign bus_if.ready = state_q == S_IDLE;
  assign bus_if.done  = (state_q == S_T1 && !swap) || state_q == S_T3;
endmodule

// File: tb/tb_regbus_sequencer.sv
// tb_regbus_sequencer: randomized self-checking bench against a command-level register model
module tb_regbus_sequencer;
  import regbus_sequencer_pkg::*;
  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int AW    = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] m [NREGS];
  regbus_sequencer_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bif ();
  regbus_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bif)
  );
  always #5 clk = ~clk;

  function automatic logic [NREGS*WIDTH-1:0] flat();
    logic [NREGS*WIDTH-1:0] f;
    for (int i = 0; i < NREGS; i++) f[i*WIDTH +: WIDTH] = m[i];
    return f;
  endfunction

  // Called at the negedge of an idle cycle; returns at the negedge of the following idle cycle.
  task automatic run_cmd(input logic [1:0] op, input int rx, input int ry,
                         input logic [WIDTH-1:0] din, input bit hold, input bit pulse);
    logic [WIDTH-1:0] exp_bus [3];
    logic [WIDTH-1:0] tmp;
    int n;
    n = op == OP_SWAP ? 3 : 1;
    exp_bus[0] = op == OP_MV ? m[ry] : op == OP_MVI ? din : op == OP_SWAP ? m[rx] : '0;
    exp_bus[1] = m[ry];
    exp_bus[2] = m[rx];
    bif.run = 1'b1;
    bif.op  = op;
    bif.rx  = AW'(rx);
    bif.ry  = AW'(ry);
    bif.din = din;
    @(posedge clk);
    #1;
    bif.run = hold;
    bif.op  = 2'($urandom);
    bif.rx  = AW'($urandom);
    bif.ry  = AW'($urandom);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        bif.run = hold || (pulse && k == 1);
        bif.din = WIDTH'($urandom);
        if (pulse && k == 1) begin
          bif.op = OP_CLR;
          bif.rx = '0;
        end
      end
      @(negedge clk);
      n_chk++;
      if (bif.bus !== exp_bus[k] || bif.done !== (k == n - 1) || bif.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL cmd op=%0d rx=%0d ry=%0d cycle T%0d: bus=%h done=%b ready=%b, want bus=%h done=%b ready=0",
                 op, rx, ry, k + 1, bif.bus, bif.done, bif.ready, exp_bus[k], k == n - 1);
      end
    end
    case (op)
      OP_MV:   m[rx] = m[ry];
      OP_MVI:  m[rx] = din;
      OP_CLR:  m[rx] = '0;
      default: begin tmp = m[rx]; m[rx] = m[ry]; m[ry] = tmp; end
    endcase
    @(posedge clk);
    #1;
    bif.run = hold;
    @(negedge clk);
    n_chk++;
    if (bif.ready !== 1'b1 || bif.done !== 1'b0 || bif.bus !== '0 || bif.regs !== flat()) begin
      n_fail++;
      $display("FAIL idle after op=%0d: ready=%b done=%b bus=%h regs=%h, want ready=1 done=0 bus=00 regs=%h",
               op, bif.ready, bif.done, bif.bus, bif.regs, flat());
    end
  endtask

  task automatic test_reset();
    bif.run = 1'b1;
    bif.op  = OP_MVI;
    bif.rx  = 2'd2;
    bif.ry  = 2'd0;
    bif.din = 8'hFF;
    #3;
    n_chk++;
    if (bif.ready !== 1'b1 || bif.done !== 1'b0 || bif.bus !== '0 || bif.regs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b done=%b bus=%h regs=%h, want 1 0 00 0", bif.ready, bif.done, bif.bus, bif.regs);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (bif.ready !== 1'b1 || bif.regs !== '0) begin
      n_fail++;
      $display("FAIL reset_ignores_run: ready=%b regs=%h, want 1 0", bif.ready, bif.regs);
    end
    @(negedge clk);
    rst = 1'b0;
    bif.run = 1'b0;
    for (int i = 0; i < NREGS; i++) m[i] = '0;
  endtask

  task automatic test_mvi();
    run_cmd(OP_MVI, 2, 0, 8'hA5, 0, 0);
    n_chk++;
    if (bif.regs !== 32'h00A5_0000) begin
      n_fail++;
      $display("FAIL mvi_r2: regs=%h, want 00a50000", bif.regs);
    end
  endtask

  task automatic test_mv();
    run_cmd(OP_MVI, 0, 0, 8'h11, 0, 0);
    run_cmd(OP_MVI, 3, 0, 8'h3C, 0, 0);
    run_cmd(OP_MV, 1, 3, 8'h00, 0, 0);
    n_chk++;
    if (bif.regs !== 32'h3CA5_3C11) begin
      n_fail++;
      $display("FAIL mv_r1_r3: regs=%h, want 3ca53c11", bif.regs);
    end
  endtask

  task automatic test_swap();
    run_cmd(OP_MVI, 1, 0, 8'h22, 0, 0);
    run_cmd(OP_SWAP, 0, 1, 8'h00, 0, 0);
    n_chk++;
    if (bif.regs !== 32'h3CA5_1122) begin
      n_fail++;
      $display("FAIL swap_r0_r1: regs=%h, want 3ca51122", bif.regs);
    end
  endtask

  task automatic test_ignore_run();
    run_cmd(OP_SWAP, 0, 1, 8'h00, 0, 1);
    n_chk++;
    if (bif.regs !== 32'h3CA5_2211) begin
      n_fail++;
      $display("FAIL busy_run_ignored: regs=%h, want 3ca52211", bif.regs);
    end
    run_cmd(OP_CLR, 0, 0, 8'h00, 0, 0);
    n_chk++;
    if (bif.regs !== 32'h3CA5_2200) begin
      n_fail++;
      $display("FAIL clr_r0: regs=%h, want 3ca52200", bif.regs);
    end
  endtask

  task automatic test_reset_mid_swap();
    bif.run = 1'b1;
    bif.op  = OP_SWAP;
    bif.rx  = 2'd0;
    bif.ry  = 2'd1;
    @(posedge clk);
    #1;
    bif.run = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bif.ready !== 1'b1 || bif.done !== 1'b0 || bif.bus !== '0 || bif.regs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_swap: ready=%b done=%b bus=%h regs=%h, want 1 0 00 0", bif.ready, bif.done, bif.bus, bif.regs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) m[i] = '0;
    run_cmd(OP_MVI, 3, 0, 8'hFF, 0, 0);
    n_chk++;
    if (bif.regs !== 32'hFF00_0000) begin
      n_fail++;
      $display("FAIL mvi_after_reset: regs=%h, want ff000000", bif.regs);
    end
  endtask

  task automatic test_boundary();
    logic [WIDTH-1:0] v;
    v = WIDTH'($urandom);
    run_cmd(OP_MVI, 2, 0, v, 0, 0);
    run_cmd(OP_MV, 2, 2, 8'h00, 0, 0);
    run_cmd(OP_MVI, 1, 0, ~v, 0, 0);
    run_cmd(OP_SWAP, 1, 1, 8'h00, 0, 0);
    n_chk++;
    if (bif.regs[23:16] !== v || bif.regs[15:8] !== ~v) begin
      n_fail++;
      $display("FAIL self_mv_swap: r2=%h r1=%h, want %h %h", bif.regs[23:16], bif.regs[15:8], v, ~v);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    for (int i = 0; i < 10; i++)
      run_cmd(i % 2 ? OP_MVI : OP_MV, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              WIDTH'($urandom), i != 9, 0);
    n_chk++;
    if ($time - t0 !== 200) begin
      n_fail++;
      $display("FAIL back_to_back_rate: elapsed=%0t, want 200", $time - t0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_cmd(2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              WIDTH'($urandom), i != 29 && $urandom_range(0, 1) == 1, 0);
  endtask

  initial begin
    bif.run = 1'b0;
    bif.op  = '0;
    bif.rx  = '0;
    bif.ry  = '0;
    bif.din = '0;
    test_reset();
    test_mvi();
    test_mv();
    test_swap();
    test_ignore_run();
    test_reset_mid_swap();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
